// File: rtl/ft_bus_arbiter.sv
// FT245 synchronous-FIFO bus arbiter: alternates RX read bursts and TX write
// bursts on the shared FT245 bus, with optional SIWU flush after TX data.
module ft_bus_arbiter #(
  parameter int unsigned RX_BURST_MAX = 512,
  parameter int unsigned TX_BURST_MAX = 512
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ftdi_rde_n,
  input  logic       ftdi_txe_n,
  input  logic [7:0] ftdi_data_in,
  output logic [7:0] ftdi_data_out,
  output logic       ftdi_data_oe,
  output logic       ftdi_oe_n,
  output logic       ftdi_rd_n,
  output logic       ftdi_wr_n,
  output logic       ftdi_siwu,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       tx_flush
);

  localparam int unsigned RXW = $clog2(RX_BURST_MAX + 1);
  localparam int unsigned TXW = $clog2(TX_BURST_MAX + 1);
  localparam logic [RXW-1:0] RX_MAX = RXW'(RX_BURST_MAX);
  localparam logic [TXW-1:0] TX_MAX = TXW'(TX_BURST_MAX);

  typedef enum logic [2:0] {
    IDLE,
    RX_OE,
    RX_READ,
    TURN,
    TX_WRITE,
    SIWU
  } state_e;

  state_e         state_q;
  logic           oe_n_q;
  logic           rd_n_q;
  logic           wr_n_q;
  logic           siwu_q;
  logic           data_oe_q;
  logic [7:0]     data_out_q;
  logic [7:0]     rx_data_q;
  logic           rx_valid_q;
  logic [RXW-1:0] rx_cnt_q;
  logic [RXW-1:0] rx_cnt_d;
  logic [TXW-1:0] tx_cnt_q;
  logic [TXW-1:0] tx_cnt_d;
  logic           flush_q;
  logic           flush_d;
  logic           last_tx_q;

  logic rx_pend;
  logic tx_pend;
  logic rx_cap;
  logic rx_exit;
  logic tx_commit;
  logic tx_exit;

  // The TX holding register is full exactly while wr_n is low, so wr_n_q
  // doubles as its occupancy flag.
  always_comb begin
    rx_pend   = ~ftdi_rde_n & rx_ready;
    tx_pend   = tx_valid & ~ftdi_txe_n;
    rx_cap    = (state_q == RX_READ) & ~rd_n_q & ~ftdi_rde_n & (rx_cnt_q != RX_MAX);
    rx_cnt_d  = rx_cnt_q + RXW'(rx_cap);
    rx_exit   = ftdi_rde_n | ~rx_ready | (rx_cnt_d == RX_MAX);
    tx_commit = (state_q == TX_WRITE) & ~wr_n_q & ~ftdi_txe_n;
    // With txe_n low the holding register is either empty or committing.
    tx_ready  = (state_q == TX_WRITE) & tx_valid & ~ftdi_txe_n & (tx_cnt_q != TX_MAX);
    tx_cnt_d  = tx_cnt_q + TXW'(tx_ready);
    tx_exit   = wr_n_q & ~tx_ready;
    flush_d   = tx_flush | (flush_q & (state_q != SIWU));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      oe_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      siwu_q     <= 1'b1;
      data_oe_q  <= 1'b0;
      data_out_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      flush_q    <= 1'b0;
      last_tx_q  <= 1'b1;
    end else begin
      rx_valid_q <= rx_cap;
      if (rx_cap) begin
        rx_data_q <= ftdi_data_in;
      end
      rx_cnt_q <= rx_cnt_d;
      tx_cnt_q <= tx_cnt_d;
      flush_q  <= flush_d;

      unique case (state_q)
        IDLE: begin
          if (rx_pend && (!tx_pend || last_tx_q)) begin
            state_q   <= RX_OE;
            oe_n_q    <= 1'b0;
            rx_cnt_q  <= '0;
            last_tx_q <= 1'b0;
          end else if (tx_pend) begin
            state_q   <= TX_WRITE;
            data_oe_q <= 1'b1;
            tx_cnt_q  <= '0;
            last_tx_q <= 1'b1;
          end else if (flush_q && !ftdi_txe_n) begin
            state_q <= SIWU;
            siwu_q  <= 1'b0;
          end
        end

        RX_OE: begin
          state_q <= RX_READ;
          rd_n_q  <= 1'b0;
        end

        RX_READ: begin
          if (rx_exit) begin
            state_q <= TURN;
            rd_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
          end
        end

        TURN: begin
          state_q <= IDLE;
        end

        TX_WRITE: begin
          if (tx_ready) begin
            data_out_q <= tx_data;
            wr_n_q     <= 1'b0;
          end else if (tx_commit) begin
            wr_n_q <= 1'b1;
          end
          if (tx_exit) begin
            data_oe_q <= 1'b0;
            if (flush_q) begin
              state_q <= SIWU;
              siwu_q  <= 1'b0;
            end else begin
              state_q <= TURN;
            end
          end
        end

        SIWU: begin
          siwu_q  <= 1'b1;
          state_q <= TURN;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ftdi_data_out = data_out_q;
  assign ftdi_data_oe  = data_oe_q;
  assign ftdi_oe_n     = oe_n_q;
  assign ftdi_rd_n     = rd_n_q;
  assign ftdi_wr_n     = wr_n_q;
  assign ftdi_siwu     = siwu_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;

endmodule
